// File: rtl/sgdmac_wr_engine_if.sv
// Bundle between the SG-DMA write drain and its neighbours: command, FIFO read
// port and the AXI4 AW/W/B channels. master = engine side, slave = environment.
interface sgdmac_wr_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic [LEN_WIDTH-1:0]    cmd_len_i;
  logic                    done_o;
  logic                    err_o;

  logic                    fifo_empty_i;
  logic [CW-1:0]           fifo_free_i;
  logic                    fifo_rden_o;
  logic [DATA_WIDTH-1:0]   fifo_rdata_i;

  logic [ADDR_WIDTH-1:0]   awaddr_o;
  logic [3:0]              awlen_o;
  logic [2:0]              awsize_o;
  logic [1:0]              awburst_o;
  logic                    awvalid_o;
  logic                    awready_i;

  logic [DATA_WIDTH-1:0]   wdata_o;
  logic [DATA_WIDTH/8-1:0] wstrb_o;
  logic                    wlast_o;
  logic                    wvalid_o;
  logic                    wready_i;

  logic [1:0]              bresp_i;
  logic                    bvalid_i;
  logic                    bready_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, fifo_empty_i, fifo_free_i, fifo_rdata_i,
           awready_i, wready_i, bresp_i, bvalid_i,
    output cmd_ready_o, done_o, err_o, fifo_rden_o, awaddr_o, awlen_o, awsize_o, awburst_o,
           awvalid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, fifo_empty_i, fifo_free_i, fifo_rdata_i,
           awready_i, wready_i, bresp_i, bvalid_i,
    input  cmd_ready_o, done_o, err_o, fifo_rden_o, awaddr_o, awlen_o, awsize_o, awburst_o,
           awvalid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o
  );
endinterface

// File: rtl/sgdmac_wr_engine.sv
// SG-DMA write drain: turns one (addr, len) command into AXI4 INCR bursts fed
// from a FWFT FIFO, one burst outstanding at a time, then pulses done/err.
module sgdmac_wr_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                clk,
  input  logic                rst,
  sgdmac_wr_engine_if.master  bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic [2:0] {IDLE, REQ, AW, W, B, DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, awaddr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [4:0]            burst_q, cnt_q;
  logic [3:0]            awlen_q;
  logic                  err_q, errout_q, done_q, cmd_ready_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q;

  logic [12:0]           bnd_beats;
  logic [BW-1:0]         burst_d;
  logic [CW-1:0]         occ;
  logic                  err_d;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [LEN_WIDTH-1:0]  cmd_beats;

  assign cmd_beats = bus.cmd_len_i >> BSH;
  assign bnd_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> BSH;
  assign occ       = CW'(FIFO_DEPTH) - bus.fifo_free_i;
  assign err_d     = err_q | (bus.bresp_i != 2'b00);
  assign addr_inc  = ADDR_WIDTH'(burst_q) << BSH;

  // Burst never crosses a 4 KB page and never exceeds what is left.
  always_comb begin
    burst_d = BW'(rem_q);
    if (burst_d > BW'(MAX_BURST)) burst_d = BW'(MAX_BURST);
    if (burst_d > BW'(bnd_beats)) burst_d = BW'(bnd_beats);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      awaddr_q    <= '0;
      rem_q       <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      awlen_q     <= '0;
      err_q       <= 1'b0;
      errout_q    <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid_i) begin
          addr_q      <= bus.cmd_addr_i;
          rem_q       <= cmd_beats;
          err_q       <= 1'b0;
          cmd_ready_q <= 1'b0;
          if (cmd_beats == '0) begin
            done_q   <= 1'b1;
            errout_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            state_q  <= REQ;
          end
        end
        // Launch only once the whole burst sits in the FIFO, so W never starves.
        REQ: if (BW'(occ) >= burst_d) begin
          awaddr_q  <= addr_q;
          awlen_q   <= 4'(burst_d - 1'b1);
          burst_q   <= 5'(burst_d);
          cnt_q     <= 5'(burst_d);
          awvalid_q <= 1'b1;
          state_q   <= AW;
        end
        AW: if (bus.awready_i) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          wlast_q   <= (cnt_q == 5'd1);
          state_q   <= W;
        end
        W: if (bus.wready_i) begin
          cnt_q   <= cnt_q - 5'd1;
          wlast_q <= (cnt_q == 5'd2);
          if (wlast_q) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: if (bus.bvalid_i) begin
          bready_q <= 1'b0;
          err_q    <= err_d;
          addr_q   <= addr_q + addr_inc;
          rem_q    <= rem_q - LEN_WIDTH'(burst_q);
          if (rem_q == LEN_WIDTH'(burst_q)) begin
            done_q   <= 1'b1;
            errout_q <= err_d;
            state_q  <= DONE;
          end else begin
            state_q  <= REQ;
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          errout_q    <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = errout_q;
  assign bus.awaddr_o    = awaddr_q;
  assign bus.awlen_o     = awlen_q;
  assign bus.awsize_o    = 3'(BSH);
  assign bus.awburst_o   = 2'b01;
  assign bus.awvalid_o   = awvalid_q;
  assign bus.wdata_o     = bus.fifo_rdata_i;
  assign bus.wstrb_o     = '1;
  assign bus.wlast_o     = wlast_q;
  assign bus.wvalid_o    = wvalid_q;
  assign bus.bready_o    = bready_q;
  assign bus.fifo_rden_o = wvalid_q & bus.wready_i;

  // A starved W beat means the REQ occupancy gate is broken.
  a_w_not_starved: assert property (@(posedge clk) disable iff (rst)
    !(bus.wvalid_o && bus.fifo_empty_i));
endmodule
